// File: rtl/whirlpool_pkg.sv
// Shared sizes and byte addressing for the Whirlpool state.
// A state is 8 rows x 8 bytes; byte (r,c) sits at bit 64r+8c.
package whirlpool_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int BYTE_W  = 8;
    localparam int ROW_W   = 64;
    localparam int STATE_W = 512;

    function automatic logic [8:0] byte_off(
        input logic [2:0] r,
        input logic [2:0] c
    );
        return {r, 6'b0} + {3'b0, c, 3'b0};
    endfunction

endpackage

// File: rtl/whirlpool_pi_row_sel.sv
// Combinational Pi row picker: one permuted row out of a stored state.
// Column c of the output row comes from a row rotated by c.
module whirlpool_pi_row_sel
    import whirlpool_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic [0:STATE_W-1] bank,
    input  logic [2:0]         row,
    output logic [0:ROW_W-1]   perm
);

    logic [2:0] src;

    // Gather byte c of the output row from source row (row +/- c) mod 8.
    always_comb begin
        perm = '0;
        src  = '0;
        for (int c = 0; c < COLS; c++) begin
            src = INVERSE ? row + 3'(c) : row - 3'(c);
            perm[c*BYTE_W +: BYTE_W] =
                bank[byte_off(src, 3'(c)) +: BYTE_W];
        end
    end

endmodule

// File: rtl/whirlpool_wcipher_pi_stream.sv
// Row-serial Whirlpool Pi permuter with a two-bank ping-pong buffer.
// One bank fills while the other drains, giving one row per clock.
module whirlpool_wcipher_pi_stream
    import whirlpool_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [0:ROW_W-1] i_row,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [0:ROW_W-1] o_row,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_busy
);

    logic [0:STATE_W-1] bank [2];
    logic [0:1]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [2:0]         wr_cnt;
    logic [2:0]         rd_cnt;
    logic               wr_fire;
    logic               rd_fire;

    assign o_ready = !full[wr_bank];
    assign wr_fire = i_valid & o_ready;
    assign o_valid = full[rd_bank];
    assign rd_fire = o_valid & i_ready;
    assign o_last  = o_valid & (rd_cnt == 3'd7);
    assign o_busy  = full[0] | full[1] | (wr_cnt != 3'd0);

    // Row storage: not reset, contents only matter once a bank is full.
    always_ff @(posedge i_clk) begin
        if (wr_fire)
            bank[wr_bank][byte_off(wr_cnt, 3'd0) +: ROW_W] <= i_row;
    end

    // Fill and drain bookkeeping; the two sides always touch
    // different banks, so same-cycle updates never collide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 3'd1;
                if (wr_cnt == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 3'd1;
                if (rd_cnt == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    whirlpool_pi_row_sel #(
        .INVERSE (INVERSE)
    ) u_row_sel (
        .bank (bank[rd_bank]),
        .row  (rd_cnt),
        .perm (o_row)
    );

endmodule

// File: tb/tb_whirlpool_wcipher_pi_stream.sv
// Directed and randomized bench for the Pi stream permuter.
// Expected rows are queued as stimulus is driven and popped on output.
module tb_whirlpool_wcipher_pi_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc++;

    logic [0:63] in_row = '0;
    logic        in_valid = 1'b0;
    logic        inv_ready, inv_valid, inv_last, inv_busy;
    logic [0:63] inv_row;
    logic        out_ready = 1'b1;

    logic        fwd_valid = 1'b0;
    logic        fwd_ready, fwd_ovalid, fwd_last, fwd_busy;
    logic [0:63] fwd_row;
    logic        fwd_oready = 1'b1;

    logic [0:63] rt_row = '0;
    logic        rt_valid = 1'b0;
    logic        rt_ready;
    logic [0:63] mid_row;
    logic        mid_valid, mid_ready, mid_last, rtf_busy;
    logic [0:63] rt_orow;
    logic        rt_ovalid, rt_olast, rti_busy;
    logic        rt_oready = 1'b0;

    whirlpool_wcipher_pi_stream #(.INVERSE(1'b1)) u_inv (
        .i_clk(clk), .i_rst(rst), .i_row(in_row), .i_valid(in_valid),
        .o_ready(inv_ready), .o_row(inv_row), .o_valid(inv_valid),
        .i_ready(out_ready), .o_last(inv_last), .o_busy(inv_busy)
    );

    whirlpool_wcipher_pi_stream #(.INVERSE(1'b0)) u_fwd (
        .i_clk(clk), .i_rst(rst), .i_row(in_row), .i_valid(fwd_valid),
        .o_ready(fwd_ready), .o_row(fwd_row), .o_valid(fwd_ovalid),
        .i_ready(fwd_oready), .o_last(fwd_last), .o_busy(fwd_busy)
    );

    whirlpool_wcipher_pi_stream #(.INVERSE(1'b0)) rt_f (
        .i_clk(clk), .i_rst(rst), .i_row(rt_row), .i_valid(rt_valid),
        .o_ready(rt_ready), .o_row(mid_row), .o_valid(mid_valid),
        .i_ready(mid_ready), .o_last(mid_last), .o_busy(rtf_busy)
    );

    whirlpool_wcipher_pi_stream #(.INVERSE(1'b1)) rt_i (
        .i_clk(clk), .i_rst(rst), .i_row(mid_row), .i_valid(mid_valid),
        .o_ready(mid_ready), .o_row(rt_orow), .o_valid(rt_ovalid),
        .i_ready(rt_oready), .o_last(rt_olast), .o_busy(rti_busy)
    );

    logic [64:0] inv_q [$];
    logic [64:0] fwd_q [$];
    logic [0:63] rt_q [$];
    logic [0:63] inv_cap [8];
    logic [0:63] fwd_cap [8];
    int inv_n = 0, fwd_n = 0, rt_n = 0;
    int t_acc = -1, t_val = -1;
    bit lat_arm = 1'b0;
    int run = 0, maxrun = 0, stall = 0;

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [0:63] perm(input logic [0:511] s,
                                         input bit inv, input int r);
        logic [0:63] o;
        int src;
        for (int c = 0; c < 8; c++) begin
            src = inv ? (r + c) % 8 : (r - c + 8) % 8;
            o[c*8 +: 8] = s[src*64 + c*8 +: 8];
        end
        return o;
    endfunction

    function automatic logic [0:511] pat_state();
        logic [0:511] s;
        logic [3:0] rr, cc;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                rr = 4'(r);
                cc = 4'(c);
                s[r*64 + c*8 +: 8] = {rr, cc};
            end
        return s;
    endfunction

    function automatic logic [0:511] rnd_state();
        logic [0:511] s;
        for (int i = 0; i < 16; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // Output monitors: pop the scoreboard on each output handshake.
    always @(negedge clk) begin
        logic [64:0] e;
        if (inv_valid && out_ready) begin
            n_chk++;
            assert (inv_q.size() > 0) n_pass++;
            else $error("FAIL inv_extra: observed row %h expected none",
                        inv_row);
            if (inv_q.size() > 0) begin
                e = inv_q.pop_front();
                chk("inv_row", {inv_last, inv_row}, e);
                inv_cap[inv_n % 8] = inv_row;
                inv_n++;
            end
        end
        if (fwd_ovalid && fwd_oready) begin
            n_chk++;
            assert (fwd_q.size() > 0) n_pass++;
            else $error("FAIL fwd_extra: observed row %h expected none",
                        fwd_row);
            if (fwd_q.size() > 0) begin
                e = fwd_q.pop_front();
                chk("fwd_row", {fwd_last, fwd_row}, e);
                fwd_cap[fwd_n % 8] = fwd_row;
                fwd_n++;
            end
        end
        if (rt_ovalid && rt_oready) begin
            n_chk++;
            assert (rt_q.size() > 0) n_pass++;
            else $error("FAIL rt_extra: observed row %h expected none",
                        rt_orow);
            if (rt_q.size() > 0) begin
                e = {(rt_n % 8 == 7), rt_q.pop_front()};
                chk("rt_row", {rt_olast, rt_orow}, e);
                rt_n++;
            end
        end
        if (lat_arm && in_valid && inv_ready && t_acc < 0) t_acc = cyc;
        if (lat_arm && inv_valid && t_val < 0) t_val = cyc;
        run = inv_valid ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
    end

    // Random downstream throttling for the round-trip chain.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rt_oready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_row(input logic [0:63] row);
        int n;
        in_row = row;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!inv_ready && n < 200) begin
            n++;
            stall++;
            @(negedge clk);
        end
        if (n >= 200) chk("in_timeout", inv_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_inv(input logic [0:511] s);
        for (int r = 0; r < 8; r++)
            inv_q.push_back({(r == 7), perm(s, 1'b1, r)});
        for (int r = 0; r < 8; r++) send_row(s[r*64 +: 64]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((inv_q.size() != 0 || inv_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("inv_drain", 65'(inv_q.size()), 65'd0);
    endtask

    initial begin
        logic [0:511] ps, s;
        int n;
        ps = pat_state();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", inv_valid, 1'b0);
        chk("rst_last", inv_last, 1'b0);
        chk("rst_busy", inv_busy, 1'b0);
        chk("rst_ready", inv_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Inverse mapping and latency
        lat_arm = 1'b1;
        inv_n = 0;
        send_inv(ps);
        wait_drain();
        lat_arm = 1'b0;
        chk("latency", 65'(t_val - t_acc), 65'd8);
        chk("inv_r0", inv_cap[0], 64'h0011223344556677);
        chk("inv_r1", inv_cap[1], 64'h1021324354657607);
        chk("inv_r7", inv_cap[7], 64'h7001122334455667);

        // Forward mapping
        for (int r = 0; r < 8; r++)
            fwd_q.push_back({(r == 7), perm(ps, 1'b0, r)});
        fwd_n = 0;
        for (int r = 0; r < 8; r++) begin
            in_row = ps[r*64 +: 64];
            fwd_valid = 1'b1;
            @(negedge clk);
            chk("fwd_ready", fwd_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        fwd_valid = 1'b0;
        n = 0;
        while ((fwd_q.size() != 0 || fwd_ovalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fwd_drain", 65'(fwd_q.size()), 65'd0);
        chk("fwd_r0", fwd_cap[0], 64'h0071625344352617);
        chk("fwd_r7", fwd_cap[7], 64'h7061524334251607);

        // Throughput: three back-to-back states
        maxrun = 0;
        stall = 0;
        send_inv(ps);
        send_inv(rnd_state());
        send_inv(rnd_state());
        wait_drain();
        chk("tp_stall", 65'(stall), 65'd0);
        chk("tp_run", 65'(maxrun), 65'd24);

        // Backpressure after the first output row
        fork
            begin
                send_inv(ps);
                send_inv(rnd_state());
            end
            begin
                n = 0;
                @(negedge clk);
                while (!(inv_valid && out_ready) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", inv_ready, 1'b0);
            chk("bp_valid", inv_valid, 1'b1);
            chk("bp_last", inv_last, 1'b0);
            chk("bp_row", inv_row, 64'h1021324354657607);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset with one stored state plus a partial load
        out_ready = 1'b0;
        send_inv(rnd_state());
        s = rnd_state();
        for (int r = 0; r < 5; r++) send_row(s[r*64 +: 64]);
        chk("pre_rst_busy", inv_busy, 1'b1);
        chk("pre_rst_valid", inv_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", inv_valid, 1'b0);
        chk("mid_rst_busy", inv_busy, 1'b0);
        chk("mid_rst_ready", inv_ready, 1'b1);
        chk("mid_rst_last", inv_last, 1'b0);
        inv_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_inv(rnd_state());
        wait_drain();

        // Round trip: forward chained into inverse, random throttling
        rt_n = 0;
        for (int k = 0; k < 100; k++) begin
            s = rnd_state();
            for (int r = 0; r < 8; r++) begin
                rt_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                rt_row = s[r*64 +: 64];
                rt_valid = 1'b1;
                n = 0;
                @(negedge clk);
                while (!rt_ready && n < 500) begin
                    n++;
                    @(negedge clk);
                end
                if (n >= 500) chk("rt_in_timeout", rt_ready, 1'b1);
                rt_q.push_back(rt_row);
                @(posedge clk);
                #1;
            end
        end
        rt_valid = 1'b0;
        n = 0;
        while ((rt_q.size() != 0 || rt_ovalid) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rt_drain", 65'(rt_q.size()), 65'd0);
        chk("rt_count", 65'(rt_n), 65'd800);

        chk("idle_busy", {mid_last, fwd_busy, rtf_busy, rti_busy, inv_busy},
            65'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
